bus_arb2: RTL and testbench

BUS_ARB2 -- requirements
Module: bus_arb2

---
 rtl/bus_arb2_pkg.sv | 28 ++
 rtl/bus_arb2_if.sv | 57 +++++
 rtl/bus_arb2.sv | 131 +++++++++++++
 tb/tb_bus_arb2.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb2_pkg.sv
// ----------------------------------------------------------------------------
// bus_arb2_pkg : shared bus types, arbiter defaults and mapper address map
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arb2_pkg;

  localparam int unsigned c_data_w = 32;
  localparam int unsigned c_cnt_w  = 10;

  localparam int unsigned                c_timeout_default  = 1023;
  localparam logic [c_data_w-1:0]        c_err_data_default = 32'h0000_0000;

  // Address mapper regions
  localparam logic [c_data_w-1:0] c_map_ram_base = 32'h1000_0000;
  localparam logic [c_data_w-1:0] c_map_io_base  = 32'h2000_0000;
  localparam logic [c_data_w-1:0] c_map_bad_base = 32'h9900_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

endpackage : bus_arb2_pkg

`default_nettype wire

// File: rtl/bus_arb2_if.sv
// ----------------------------------------------------------------------------
// bus_arb2_if : two master ports plus the shared downstream mapper bus
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bus_arb2_if;
  import bus_arb2_pkg::*;

  logic [c_data_w-1:0] m0_a;
  logic [c_data_w-1:0] m0_d;
  logic                m0_we;
  logic                m0_rd;
  logic [c_data_w-1:0] m0_spo;
  logic                m0_ready;

  logic [c_data_w-1:0] m1_a;
  logic [c_data_w-1:0] m1_d;
  logic                m1_we;
  logic                m1_rd;
  logic [c_data_w-1:0] m1_spo;
  logic                m1_ready;

  logic [c_data_w-1:0] a;
  logic [c_data_w-1:0] d;
  logic                we;
  logic                rd;
  logic [c_data_w-1:0] spo;
  logic                ready;
  logic                bus_err;
  logic                owner;

  // Arbiter side: drives the mapper bus and the per-master responses
  modport master (
    input  m0_a, m0_d, m0_we, m0_rd,
    output m0_spo, m0_ready,
    input  m1_a, m1_d, m1_we, m1_rd,
    output m1_spo, m1_ready,
    output a, d, we, rd,
    input  spo, ready,
    output bus_err, owner
  );

  // Environment side: the two requesting masters and the address mapper
  modport slave (
    output m0_a, m0_d, m0_we, m0_rd,
    input  m0_spo, m0_ready,
    output m1_a, m1_d, m1_we, m1_rd,
    input  m1_spo, m1_ready,
    input  a, d, we, rd,
    output spo, ready,
    input  bus_err, owner
  );

endinterface : bus_arb2_if

`default_nettype wire

// File: rtl/bus_arb2.sv
// ----------------------------------------------------------------------------
// bus_arb2 : two-master round-robin bus arbiter with wait-state timeout
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arb2
  import bus_arb2_pkg::*;
#(
  parameter int unsigned          TIMEOUT  = c_timeout_default,
  parameter logic [c_data_w-1:0]  ERR_DATA = c_err_data_default
) (
  input  wire logic   clk,
  input  wire logic   rst,
  bus_arb2_if.master  bus
);

  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 r_last;
  logic                 w_last_nxt;

  logic                 w_req0;
  logic                 w_req1;
  logic                 w_grant;
  logic                 w_sel;
  logic                 w_done;
  logic                 w_abort;
  logic [c_data_w-1:0]  w_rdata;

  assign w_req0  = bus.m0_rd | bus.m0_we;
  assign w_req1  = bus.m1_rd | bus.m1_we;
  assign w_rdata = w_abort ? ERR_DATA : bus.spo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_grant     = 1'b0;
    w_sel       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_req0 || w_req1) begin
          w_grant = 1'b1;
          // On a tie the master that was not served last wins
          w_sel   = (w_req0 && w_req1) ? ~r_last : w_req1;
          if (bus.ready) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = w_sel ? ST_OWN1 : ST_OWN0;
            w_cnt_nxt   = c_cnt_one;
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        w_grant = 1'b1;
        w_sel   = (r_state == ST_OWN1);
        if (!(w_sel ? w_req1 : w_req0)) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.ready) begin
          w_done = 1'b1;
        end else if (r_cnt == c_timeout) begin
          w_done  = 1'b1;
          w_abort = 1'b1;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_done) begin
      w_state_nxt = ST_IDLE;
      w_last_nxt  = w_sel;
    end
  end

  // Outputs are held quiet while rst is high so an abandoned transfer never completes
  always_comb begin
    bus.a        = '0;
    bus.d        = '0;
    bus.we       = 1'b0;
    bus.rd       = 1'b0;
    bus.owner    = 1'b0;
    bus.bus_err  = 1'b0;
    bus.m0_ready = 1'b0;
    bus.m0_spo   = '0;
    bus.m1_ready = 1'b0;
    bus.m1_spo   = '0;
    if (!rst && w_grant) begin
      bus.a       = w_sel ? bus.m1_a  : bus.m0_a;
      bus.d       = w_sel ? bus.m1_d  : bus.m0_d;
      bus.we      = w_sel ? bus.m1_we : bus.m0_we;
      bus.rd      = w_sel ? bus.m1_rd : bus.m0_rd;
      bus.owner   = w_sel;
      bus.bus_err = w_abort;
      if (w_done) begin
        if (w_sel) begin
          bus.m1_ready = 1'b1;
          bus.m1_spo   = w_rdata;
        end else begin
          bus.m0_ready = 1'b1;
          bus.m0_spo   = w_rdata;
        end
      end
    end
  end

endmodule : bus_arb2

`default_nettype wire

// File: tb/tb_bus_arb2.sv
// ----------------------------------------------------------------------------
// tb_bus_arb2 : directed and randomized bench for bus_arb2 with reference model
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_arb2;
  import bus_arb2_pkg::*;

  localparam int          TO  = 1023;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arb2_if bif();

  bus_arb2 #(.TIMEOUT(TO), .ERR_DATA(ERR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who holds the bus, how long it waited, who was served last
  int          m_hold = -1;
  int          m_wait = 0;
  int          m_last = 1;
  int          w;
  bit          q0, q1, done, abort;
  bit          chk_s0, chk_s1;
  logic        exp_r0 = 1'b0;
  logic        exp_r1 = 1'b0;
  logic [31:0] e_a, e_d, e_s0, e_s1;
  logic        e_we, e_rd, e_own, e_err;

  always @(negedge clk) begin
    e_a = '0; e_d = '0; e_s0 = '0; e_s1 = '0;
    e_we = 1'b0; e_rd = 1'b0; e_own = 1'b0; e_err = 1'b0;
    exp_r0 = 1'b0; exp_r1 = 1'b0;
    chk_s0 = 1'b1; chk_s1 = 1'b1;
    done = 1'b0; abort = 1'b0;
    q0 = bif.m0_rd | bif.m0_we;
    q1 = bif.m1_rd | bif.m1_we;
    if (rst) begin
      m_hold = -1; m_wait = 0; m_last = 1;
    end else begin
      if (m_hold >= 0)       w = m_hold;
      else if (q0 && q1)     w = 1 - m_last;
      else if (q0)           w = 0;
      else if (q1)           w = 1;
      else                   w = -1;
      if (w >= 0) begin
        e_a   = (w == 1) ? bif.m1_a  : bif.m0_a;
        e_d   = (w == 1) ? bif.m1_d  : bif.m0_d;
        e_we  = (w == 1) ? bif.m1_we : bif.m0_we;
        e_rd  = (w == 1) ? bif.m1_rd : bif.m0_rd;
        e_own = (w == 1);
        if (m_hold >= 0 && !((w == 1) ? q1 : q0)) m_hold = -1;
        else if (bif.ready)                          done = 1'b1;
        else if (m_hold >= 0 && m_wait == TO)        begin done = 1'b1; abort = 1'b1; end
        else if (m_hold < 0)                         begin m_hold = w; m_wait = 1; end
        else if (m_wait < 1023)                      m_wait++;
        if (done) begin
          m_last = w; m_hold = -1; e_err = abort;
          if (w == 1) begin exp_r1 = 1'b1; e_s1 = abort ? ERR : bif.spo; end
          else        begin exp_r0 = 1'b1; e_s0 = abort ? ERR : bif.spo; end
        end else begin
          if (w == 1) chk_s1 = 1'b0; else chk_s0 = 1'b0;
        end
      end
    end
    chk("a", bif.a, e_a);
    chk("d", bif.d, e_d);
    chk("we", bif.we, e_we);
    chk("rd", bif.rd, e_rd);
    chk("owner", bif.owner, e_own);
    chk("bus_err", bif.bus_err, e_err);
    chk("m0_ready", bif.m0_ready, exp_r0);
    chk("m1_ready", bif.m1_ready, exp_r1);
    if (chk_s0) chk("m0_spo", bif.m0_spo, e_s0);
    if (chk_s1) chk("m1_spo", bif.m1_spo, e_s1);
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic drive_m(input int i, input bit rd, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      bif.m0_rd = rd; bif.m0_we = we; bif.m0_a = a; bif.m0_d = d;
    end else begin
      bif.m1_rd = rd; bif.m1_we = we; bif.m1_a = a; bif.m1_d = d;
    end
  endtask

  bit          act[2];
  int          age[2];
  bit          mdone;
  int          hit;
  int          errs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_m(0, 0, 0, '0, '0);
    drive_m(1, 0, 0, '0, '0);
    bif.ready = 1'b0;
    bif.spo   = '0;
    act[0] = 0; act[1] = 0; age[0] = 0; age[1] = 0;

    // Reset state, with a request present that must not leak out
    drive_m(0, 1, 0, 32'h1000_0004, '0);
    bif.ready = 1'b1;
    @(posedge clk); @(posedge clk); #4;
    chk("rst_a", bif.a, 32'h0);
    chk("rst_rd", bif.rd, 32'h0);
    chk("rst_m0_ready", bif.m0_ready, 32'h0);
    chk("rst_owner", bif.owner, 32'h0);
    chk("rst_bus_err", bif.bus_err, 32'h0);
    nxt();
    rst = 1'b0;
    drive_m(0, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // Single-cycle read from master 0
    drive_m(0, 1, 0, c_map_ram_base, '0);
    bif.ready = 1'b1;
    bif.spo   = 32'h1234_5678;
    settle();
    chk("rd1_m0_ready", bif.m0_ready, 32'h1);
    chk("rd1_m0_spo", bif.m0_spo, 32'h1234_5678);
    chk("rd1_m1_ready", bif.m1_ready, 32'h0);
    chk("rd1_a", bif.a, 32'h1000_0000);
    nxt();
    drive_m(0, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // Both masters continuously reading from reset alternate m0, m1, m0, m1
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    drive_m(0, 1, 0, 32'h1000_0100, '0);
    drive_m(1, 1, 0, 32'h2000_0200, '0);
    bif.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_owner", bif.owner, 32'(i % 2));
      chk("rr_m0_ready", bif.m0_ready, 32'((i + 1) % 2));
      chk("rr_m1_ready", bif.m1_ready, 32'(i % 2));
      nxt();
    end
    drive_m(0, 0, 0, '0, '0);
    drive_m(1, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // m1 write stalls 5 cycles; m0 arrives in cycle 2 and waits its turn
    drive_m(1, 0, 1, c_map_io_base, 32'h0000_CAFE);
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) drive_m(0, 1, 0, 32'h1000_0040, '0);
      if (c == 7) drive_m(1, 0, 0, '0, '0);
      bif.ready = (c >= 6);
      settle();
      if (c <= 5) begin
        chk("st_m1_ready", bif.m1_ready, 32'h0);
        chk("st_owner", bif.owner, 32'h1);
        chk("st_a", bif.a, 32'h2000_0000);
      end
      if (c >= 2 && c <= 6) begin
        chk("st_m0_ready", bif.m0_ready, 32'h0);
        chk("st_m0_spo", bif.m0_spo, 32'h0);
      end
      if (c == 6) chk("st_m1_done", bif.m1_ready, 32'h1);
      if (c == 7) begin
        chk("st_m0_owner", bif.owner, 32'h0);
        chk("st_m0_done", bif.m0_ready, 32'h1);
        chk("st_m0_a", bif.a, 32'h1000_0040);
      end
      nxt();
    end
    drive_m(0, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // Timeout abort on an unmapped read
    drive_m(0, 1, 0, c_map_bad_base, '0);
    hit = -1; errs = 0;
    for (int k = 0; k < 1100 && hit < 0; k++) begin
      settle();
      if (bif.bus_err) errs++;
      if (bif.m0_ready) begin
        hit = k;
        chk("to_spo", bif.m0_spo, ERR);
        chk("to_bus_err", bif.bus_err, 32'h1);
      end
      nxt();
    end
    drive_m(0, 0, 0, '0, '0);
    settle();
    chk("to_cycle", hit, 32'd1023);
    chk("to_pulses", errs, 32'd1);
    chk("to_after_err", bif.bus_err, 32'h0);
    chk("to_after_rd", bif.rd, 32'h0);
    nxt();

    // Reset in the middle of an OWN1 wait abandons it silently
    drive_m(1, 1, 0, 32'h2000_0010, '0);
    nxt(); nxt(); nxt();
    rst = 1'b1;
    bif.ready = 1'b1;
    bif.spo   = 32'h0000_0055;
    settle();
    chk("mr_m1_ready", bif.m1_ready, 32'h0);
    chk("mr_bus_err", bif.bus_err, 32'h0);
    chk("mr_rd", bif.rd, 32'h0);
    nxt();
    rst = 1'b0;
    drive_m(1, 0, 0, '0, '0);
    drive_m(0, 1, 0, 32'h1000_0008, '0);
    settle();
    chk("mr_idle_m0_ready", bif.m0_ready, 32'h1);
    chk("mr_idle_m1_ready", bif.m1_ready, 32'h0);
    chk("mr_idle_err", bif.bus_err, 32'h0);
    nxt();
    drive_m(0, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // m0 drops its request while owning; pending m1 is served next
    drive_m(0, 1, 0, 32'h1000_0080, '0);
    nxt();
    drive_m(1, 1, 0, 32'h2000_0020, '0);
    settle();
    chk("dr_wait_owner", bif.owner, 32'h0);
    chk("dr_wait_m1_ready", bif.m1_ready, 32'h0);
    nxt();
    drive_m(0, 0, 0, '0, '0);
    settle();
    chk("dr_drop_m0_ready", bif.m0_ready, 32'h0);
    nxt();
    bif.ready = 1'b1;
    settle();
    chk("dr_m1_owner", bif.owner, 32'h1);
    chk("dr_m1_a", bif.a, 32'h2000_0020);
    chk("dr_m1_ready", bif.m1_ready, 32'h1);
    nxt();
    drive_m(1, 0, 0, '0, '0);
    bif.ready = 1'b0;

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        mdone = (i == 0) ? exp_r0 : exp_r1;
        if (act[i] && mdone) begin
          chk("req_age", 32'(age[i] <= 2100), 32'h1);
          act[i] = 0;
        end else if (act[i] && $urandom_range(0, 59) == 0) begin
          act[i] = 0;
        end else if (act[i]) begin
          age[i]++;
        end
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1;
          age[i] = 0;
          if ($urandom_range(0, 1) == 1) drive_m(i, 1, 0, $urandom, $urandom);
          else                           drive_m(i, 0, 1, $urandom, $urandom);
        end else if (!act[i]) begin
          drive_m(i, 0, 0, $urandom, $urandom);
        end
      end
      bif.ready = ($urandom_range(0, 9) < 7);
      bif.spo   = $urandom;
      nxt();
    end
    for (int i = 0; i < 2; i++) begin
      if (act[i]) chk("req_stuck", 32'(age[i] <= 2100), 32'h1);
    end

    rst = 1'b0;
    drive_m(0, 0, 0, '0, '0);
    drive_m(1, 0, 0, '0, '0);
    nxt();
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bus_arb2

`default_nettype wire
